// File: rtl/breadboard_pkg.sv
// Shared types and constants for the Breadboard decoder source stage.
package breadboard_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SHIFT   = 2'd1,
      S_PRESENT = 2'd2,
      S_SWEEP   = 2'd3
   } state_t;

   localparam int         NIBBLE_W  = 4;
   localparam logic [3:0] LAST_CODE = 4'hF;
   localparam int         DWELL_W   = 8;

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter; tc pulses on the last cycle of each DWELL-cycle period.
module dwell_counter
   import breadboard_pkg::*;
#(
   parameter int DWELL = 60
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic tc
);

   localparam logic [DWELL_W-1:0] RELOAD = DWELL_W'(DWELL - 1);

   logic [DWELL_W-1:0] count_reg;

   assign tc = en && (count_reg == '0);

   // Reloading on tc keeps every period exactly DWELL cycles long.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (load || tc) begin
         count_reg <= RELOAD;
      end else if (en) begin
         count_reg <= count_reg - 1'b1;
      end
   end

endmodule

// File: rtl/breadboard_feeder.sv
// Nibble source for the Breadboard decoder: serial assembly with a one-deep
// pending slot, or an automatic 0..F sweep with a programmable dwell.
module breadboard_feeder
   import breadboard_pkg::*;
#(
   parameter int DWELL = 60
) (
   input  logic clk,
   input  logic rst,
   input  logic mode,
   input  logic sdi,
   input  logic sdi_valid,
   output logic sdi_ready,
   output logic w,
   output logic x,
   output logic y,
   output logic z,
   output logic out_valid,
   input  logic out_ack,
   output logic sweep_done
);

   state_t              state_reg, state_next;
   logic [NIBBLE_W-1:0] shift_reg, shift_next;
   logic [NIBBLE_W-1:0] out_reg, out_next;
   logic [NIBBLE_W-1:0] pend_reg, pend_next;
   logic [NIBBLE_W-1:0] code_reg, code_next;
   logic [1:0]          bit_cnt_reg, bit_cnt_next;
   logic                pend_full_reg, pend_full_next;
   logic                out_valid_reg, out_valid_next;
   logic                ready_reg, ready_next;
   logic                done_reg, done_next;

   logic                accept;
   logic                nibble_done;
   logic [NIBBLE_W-1:0] nibble;
   logic                dwell_load;
   logic                dwell_tc;

   assign accept       = sdi_valid && ready_reg;
   assign nibble       = {shift_reg[NIBBLE_W-2:0], sdi};
   assign nibble_done  = accept && (bit_cnt_reg == 2'd3);
   assign shift_next   = accept ? nibble : shift_reg;
   assign bit_cnt_next = accept ? bit_cnt_reg + 2'd1 : bit_cnt_reg;

   dwell_counter #(.DWELL(DWELL)) u_dwell (
      .clk  (clk),
      .rst  (rst),
      .load (dwell_load),
      .en   (state_reg == S_SWEEP),
      .tc   (dwell_tc)
   );

   always_comb begin
      state_next     = state_reg;
      out_next       = out_reg;
      out_valid_next = out_valid_reg;
      pend_next      = pend_reg;
      pend_full_next = pend_full_reg;
      code_next      = code_reg;
      done_next      = 1'b0;
      dwell_load     = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (mode) begin
               state_next     = S_SWEEP;
               code_next      = '0;
               out_next       = '0;
               out_valid_next = 1'b1;
               dwell_load     = 1'b1;
            end else if (nibble_done) begin
               state_next     = S_PRESENT;
               out_next       = nibble;
               out_valid_next = 1'b1;
            end else if (accept) begin
               state_next = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (nibble_done) begin
               state_next     = S_PRESENT;
               out_next       = nibble;
               out_valid_next = 1'b1;
            end
         end

         S_PRESENT: begin
            // A nibble finishing on the ack edge bypasses the pending slot.
            if (out_ack) begin
               if (nibble_done) begin
                  out_next = nibble;
               end else if (pend_full_reg) begin
                  out_next       = pend_reg;
                  pend_full_next = 1'b0;
               end else begin
                  out_valid_next = 1'b0;
                  state_next     = (bit_cnt_next != 2'd0) ? S_SHIFT : S_IDLE;
               end
            end else if (nibble_done) begin
               pend_next      = nibble;
               pend_full_next = 1'b1;
            end
         end

         S_SWEEP: begin
            if (dwell_tc) begin
               if (!mode || code_reg == LAST_CODE) begin
                  state_next     = S_IDLE;
                  out_valid_next = 1'b0;
                  done_next      = mode && (code_reg == LAST_CODE);
               end else begin
                  code_next = code_reg + 1'b1;
                  out_next  = code_reg + 1'b1;
               end
            end
         end

         default: state_next = S_IDLE;
      endcase

      ready_next = (state_next != S_SWEEP) && !pend_full_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         shift_reg     <= '0;
         bit_cnt_reg   <= '0;
         out_reg       <= '0;
         pend_reg      <= '0;
         pend_full_reg <= 1'b0;
         code_reg      <= '0;
         out_valid_reg <= 1'b0;
         ready_reg     <= 1'b1;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         shift_reg     <= shift_next;
         bit_cnt_reg   <= bit_cnt_next;
         out_reg       <= out_next;
         pend_reg      <= pend_next;
         pend_full_reg <= pend_full_next;
         code_reg      <= code_next;
         out_valid_reg <= out_valid_next;
         ready_reg     <= ready_next;
         done_reg      <= done_next;
      end
   end

   assign {w, x, y, z} = out_reg;
   assign out_valid    = out_valid_reg;
   assign sdi_ready    = ready_reg;
   assign sweep_done   = done_reg;

endmodule

// File: tb/tb_breadboard_feeder.sv
// Scoreboard bench: accepted bits form nibbles in order; a monitor checks each presentation.
module tb_breadboard_feeder;

   localparam int DWELL = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic mode = 1'b0;
   logic sdi = 1'b0;
   logic sdi_valid = 1'b0;
   logic out_ack = 1'b0;
   logic sdi_ready, w, x, y, z, out_valid, sweep_done;

   breadboard_feeder #(.DWELL(DWELL)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .sdi        (sdi),
      .sdi_valid  (sdi_valid),
      .sdi_ready  (sdi_ready),
      .w          (w),
      .x          (x),
      .y          (y),
      .z          (z),
      .out_valid  (out_valid),
      .out_ack    (out_ack),
      .sweep_done (sweep_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] code;
      int         dur;   // expected hold length in cycles, 0 = not checked
   } item_t;

   item_t      exp_q[$];
   int         checks = 0;
   int         passes = 0;
   logic       ack_at_edge = 1'b0;
   logic [3:0] acc = 4'h0;
   int         nbits = 0;
   logic       ready_seen;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
   endtask

   // One clock: drive at negedge, book the handshake at the posedge.
   task automatic cycle(input logic v, input logic b, input logic a, output logic took);
      @(negedge clk);
      ready_seen = sdi_ready;
      sdi_valid  = v;
      sdi        = b;
      out_ack    = a;
      @(posedge clk);
      ack_at_edge = a;
      took = v && ready_seen;
      if (took) begin
         acc = {acc[2:0], b};
         nbits++;
         if (nbits == 4) begin
            exp_q.push_back('{code: acc, dur: 0});
            nbits = 0;
         end
      end
   endtask

   task automatic send_bit(input logic b, input logic a);
      logic took;
      int   n;
      n = 0;
      do begin
         cycle(1'b1, b, a, took);
         n++;
      end while (!took && n < 40);
      if (!took) check("send_bit_timeout", 0, 1);
   endtask

   task automatic send_nibble(input logic [3:0] v);
      for (int i = 3; i >= 0; i--) send_bit(v[i], 1'b0);
   endtask

   task automatic idle(input int n, input logic a);
      logic took;
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, a, took);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b1; mode = 1'b0; sdi_valid = 1'b0; sdi = 1'b0; out_ack = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_wxyz", {w, x, y, z}, 0);
      check("rst_sweep_done", sweep_done, 0);
      check("rst_sdi_ready", sdi_ready, 1);
      exp_q.delete();
      acc = 4'h0; nbits = 0; ack_at_edge = 1'b0;
      @(negedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic start_sweep();
      for (int i = 0; i < 16; i++) exp_q.push_back('{code: 4'(i), dur: DWELL});
      @(negedge clk);
      mode = 1'b1; sdi_valid = 1'b0; out_ack = 1'b0;
      @(posedge clk);
      ack_at_edge = 1'b0;
   endtask

   // Monitor: a new code is presented when out_valid rises, after an accepted ack, or when the code changes.
   initial begin
      logic       pv;
      logic [3:0] pc, code;
      logic       fresh;
      int         cur_dur, cur_len;
      item_t      it;
      pv = 1'b0; pc = 4'h0; cur_dur = 0; cur_len = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pv = 1'b0; cur_dur = 0; cur_len = 0;
         end else begin
            code  = {w, x, y, z};
            fresh = out_valid && (!pv || ack_at_edge || code != pc);
            if (cur_dur != 0 && pv && (fresh || !out_valid))
               check("dwell_len", cur_len, cur_dur);
            if (fresh) begin
               if (exp_q.size() == 0) begin
                  check("extra_code", 1, 0);
                  cur_dur = 0;
               end else begin
                  it = exp_q.pop_front();
                  check("code", code, it.code);
                  cur_dur = it.dur;
               end
               cur_len = 1;
            end else if (out_valid) begin
               cur_len++;
            end else begin
               cur_dur = 0;
            end
            check("sdi_ready", sdi_ready, !(out_valid && (exp_q.size() > 0 || cur_dur != 0)));
            pv = out_valid;
            pc = code;
         end
      end
   end

   initial begin
      logic took;

      do_reset();

      // Basic nibble B with latency check, then ack back to idle.
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      #1 check("pre_latency_valid", out_valid, 0);
      send_bit(1'b1, 1'b0);
      #1 check("latency_valid", out_valid, 1);
      idle(1, 1'b1);
      #1 check("ack_drop_valid", out_valid, 0);

      // B held, 6 goes to pending, further bits stall until ack.
      send_nibble(4'hB);
      send_nibble(4'h6);
      #1 check("pending_ready_low", sdi_ready, 0);
      cycle(1'b1, 1'b1, 1'b0, took); check("stall0", took, 0);
      cycle(1'b1, 1'b1, 1'b0, took); check("stall1", took, 0);
      cycle(1'b1, 1'b1, 1'b1, took); check("stall_ack", took, 0);
      #1 check("pending_out_valid", out_valid, 1);
      send_nibble(4'hF);
      idle(1, 1'b1);
      idle(1, 1'b1);
      #1 check("pending_drain_valid", out_valid, 0);

      // Same-edge ack and completion: 3 then 9 with no gap.
      send_nibble(4'h3);
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b1);
      #1 check("same_edge_valid", out_valid, 1);
      check("same_edge_ready", sdi_ready, 1);
      idle(1, 1'b1);
      #1 check("same_edge_done", out_valid, 0);

      // Random serial traffic.
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(1)), 1'($urandom_range(1)), ($urandom_range(3) == 0), took);
      idle(3, 1'b1);
      idle(1, 1'b0);
      check("random_drain", exp_q.size(), 0);

      // Reset after two bits: no residue in the next nibble.
      do_reset();
      send_bit(1'b1, 1'b1); send_bit(1'b1, 1'b0);
      do_reset();
      send_nibble(4'hA);
      idle(1, 1'b1);

      // Full sweep.
      do_reset();
      start_sweep();
      for (int k = 1; k <= 66; k++) begin
         #1;
         check("sweep_valid", out_valid, (k <= 16 * DWELL) ? 1 : 0);
         check("sweep_done", sweep_done, (k == 16 * DWELL + 1) ? 1 : 0);
         if (k == 16 * DWELL + 1) mode = 1'b0;
         @(posedge clk);
      end

      // Sweep aborted during code 5.
      do_reset();
      start_sweep();
      for (int k = 1; k <= 30; k++) begin
         #1;
         check("abort_valid", out_valid, (k <= 6 * DWELL) ? 1 : 0);
         check("abort_done", sweep_done, 0);
         if (k == 5 * DWELL + 2) mode = 1'b0;
         @(posedge clk);
         if (k == 5 * DWELL + 2) exp_q.delete();
      end

      // Reset in the middle of a sweep, then a clean nibble.
      do_reset();
      start_sweep();
      repeat (10) @(posedge clk);
      do_reset();
      send_nibble(4'h5);
      idle(1, 1'b1);
      idle(2, 1'b0);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_valid", out_valid, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
